// File: rtl/sys_defs.sv
// Shared definitions for the feature-value bank path: stream beat format,
// bandwidth constants and the receiver state enum used by sibling receivers.
`ifndef FV_bandwidth
`define FV_bandwidth 32
`endif
`ifndef Max_replay_Iter
`define Max_replay_Iter 8
`endif
`ifndef FV_MEM_cache_line
`define FV_MEM_cache_line 64
`endif

package sys_defs;
  localparam int FV_BW      = `FV_bandwidth;
  localparam int ITER_W     = $clog2(`Max_replay_Iter);
  localparam int CACHE_LINE = `FV_MEM_cache_line;
  localparam int FV_ADDR_W  = 16;

  // One beat of the Big-FV -> small-FV stream.
  typedef struct packed {
    logic                 sos;
    logic                 eos;
    logic [FV_BW-1:0]     FV_data;
    logic [FV_ADDR_W-1:0] A;
  } FV_MEM2FV_Bank;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } rx_state_t;
endpackage

// File: rtl/sm_fv_pingpong_mem.sv
// Two-half line store: one write port and one registered read port.
// Kept storage-only so it can be swapped for an SRAM macro.
module sm_fv_pingpong_mem #(
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_half,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_half,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_q
);
  logic [DW-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_half, wr_addr}] <= wr_data;
    rd_q <= mem[{rd_half, rd_addr}];
  end
endmodule

// File: rtl/sm_fv_stream_rx.sv
// Feature-value bank receiver: captures one replay iteration into the fill
// half of a ping-pong buffer while the other half serves single-line reads.
module sm_fv_stream_rx
  import sys_defs::*;
#(
  parameter int DEPTH = 64,
  parameter int DW    = FV_BW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  FV_MEM2FV_Bank       stream_in,
  input  logic [ITER_W-1:0]   Cur_Replay_Iter,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic [ITER_W-1:0]   rd_iter,
  output logic                buf_valid,
  output logic                fill_busy,
  output logic                fill_done,
  output logic [AW:0]         beat_cnt,
  output logic                err,
  output rx_state_t           state_dbg
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [0:0]        state, state_nxt;
  logic              wr_half;
  logic [ITER_W-1:0] iter_q;
  logic              we, commit;
  logic [DW-1:0]     mem_q;
  logic              unused_addr_hi;

  // In FILL every cycle is a beat; in IDLE only an sos beat starts one.
  assign we     = (state == ST_FILL) || stream_in.sos;
  assign commit = we && stream_in.eos;

  assign unused_addr_hi = ^stream_in.A[FV_ADDR_W-1:AW];
  assign fill_busy      = (state == ST_FILL);
  assign state_dbg      = rx_state_t'(state);
  assign rd_data        = rd_valid ? mem_q : '0;

  always_comb begin
    state_nxt = state;
    if (we) state_nxt = stream_in.eos ? ST_IDLE : ST_FILL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wr_half   <= 1'b0;
      iter_q    <= '0;
      rd_iter   <= '0;
      buf_valid <= 1'b0;
      fill_done <= 1'b0;
      rd_valid  <= 1'b0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_done <= commit;
      rd_valid  <= rd_en && buf_valid;
      if (we) begin
        if (stream_in.sos) begin
          // sos mid-fill abandons the partial stream and restarts here.
          beat_cnt <= (AW+1)'(1);
          iter_q   <= Cur_Replay_Iter;
          if (state == ST_FILL) err <= 1'b1;
        end else if (beat_cnt == CNT_MAX) begin
          err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + (AW+1)'(1);
        end
      end
      if (commit) begin
        wr_half   <= ~wr_half;
        buf_valid <= 1'b1;
        rd_iter   <= stream_in.sos ? Cur_Replay_Iter : iter_q;
      end
    end
  end

  // Reads sample the pre-commit read half on the commit edge.
  sm_fv_pingpong_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_mem (
    .clk     (clk),
    .we      (we),
    .wr_half (wr_half),
    .wr_addr (stream_in.A[AW-1:0]),
    .wr_data (DW'(stream_in.FV_data)),
    .rd_half (~wr_half),
    .rd_addr (rd_addr),
    .rd_q    (mem_q)
  );
endmodule

// File: tb/tb_sm_fv_stream_rx.sv
// Bench for sm_fv_stream_rx: directed streams, a buffer-level model checked
// every cycle, plus literal expectations at key points.
module tb_sm_fv_stream_rx;
  import sys_defs::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = FV_BW;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  FV_MEM2FV_Bank     stream_in = '0;
  logic [ITER_W-1:0] cur_iter  = '0;
  logic              rd_en     = 1'b0;
  logic [AW-1:0]     rd_addr   = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic [ITER_W-1:0] rd_iter;
  logic              buf_valid, fill_busy, fill_done, err;
  logic [AW:0]       beat_cnt;
  rx_state_t         state_dbg;

  sm_fv_stream_rx #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .stream_in       (stream_in),
    .Cur_Replay_Iter (cur_iter),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_iter         (rd_iter),
    .buf_valid       (buf_valid),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .beat_cnt        (beat_cnt),
    .err             (err),
    .state_dbg       (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer-level model: a fill image and a readable image swapped on commit.
  logic [DW-1:0]     fill_img [DEPTH];
  logic [DW-1:0]     read_img [DEPTH];
  logic [DW-1:0]     swap_tmp;
  logic              m_rd_valid  = 1'b0;
  logic [DW-1:0]     m_rd_data   = '0;
  logic              m_buf_valid = 1'b0;
  logic [ITER_W-1:0] m_rd_iter   = '0;
  logic [ITER_W-1:0] m_fill_iter = '0;
  logic              m_in_fill   = 1'b0;
  logic              m_done      = 1'b0;
  logic              m_err       = 1'b0;
  int                m_cnt       = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rd_valid  = 1'b0;
      m_rd_data   = '0;
      m_buf_valid = 1'b0;
      m_rd_iter   = '0;
      m_fill_iter = '0;
      m_in_fill   = 1'b0;
      m_done      = 1'b0;
      m_err       = 1'b0;
      m_cnt       = 0;
    end else begin
      m_rd_valid = rd_en && m_buf_valid;
      m_rd_data  = m_rd_valid ? read_img[rd_addr] : '0;
      m_done     = 1'b0;
      if (stream_in.sos || m_in_fill) begin
        if (stream_in.sos) begin
          if (m_in_fill) m_err = 1'b1;
          m_cnt       = 1;
          m_fill_iter = cur_iter;
        end else if (m_cnt >= DEPTH) begin
          m_err = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        fill_img[stream_in.A % DEPTH] = stream_in.FV_data;
        if (stream_in.eos) begin
          for (int i = 0; i < DEPTH; i++) begin
            swap_tmp    = read_img[i];
            read_img[i] = fill_img[i];
            fill_img[i] = swap_tmp;
          end
          m_buf_valid = 1'b1;
          m_rd_iter   = m_fill_iter;
          m_done      = 1'b1;
          m_in_fill   = 1'b0;
        end else begin
          m_in_fill = 1'b1;
        end
      end
    end
  end

  // Scoreboard compare on the falling edge, every cycle.
  always @(negedge clk) begin
    chk("rd_valid",  64'(rd_valid),  64'(m_rd_valid));
    chk("rd_data",   64'(rd_data),   64'(m_rd_data));
    chk("buf_valid", 64'(buf_valid), 64'(m_buf_valid));
    chk("rd_iter",   64'(rd_iter),   64'(m_rd_iter));
    chk("fill_busy", 64'(fill_busy), 64'(m_in_fill));
    chk("fill_done", 64'(fill_done), 64'(m_done));
    chk("beat_cnt",  64'(beat_cnt),  64'(m_cnt));
    chk("err",       64'(err),       64'(m_err));
    chk("state_dbg", 64'(state_dbg), 64'(m_in_fill));
  end

  // driver: apply one cycle of inputs, return 2 time units after the edge
  task automatic drive(input logic s, input logic e, input int a, input int d,
                       input int it, input logic re, input int ra);
    stream_in.sos     = s;
    stream_in.eos     = e;
    stream_in.A       = FV_ADDR_W'(a);
    stream_in.FV_data = FV_BW'(d);
    cur_iter          = ITER_W'(it);
    rd_en             = re;
    rd_addr           = AW'(ra);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_read(input logic re, input int ra);
    drive(1'b0, 1'b0, 0, 0, 0, re, ra);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    chk("reset_buf_valid", 64'(buf_valid), 64'd0);
    chk("reset_beat_cnt",  64'(beat_cnt),  64'd0);

    // read before any stream
    idle_read(1'b1, 3);
    chk("early_rd_valid", 64'(rd_valid), 64'd0);
    chk("early_rd_data",  64'(rd_data),  64'd0);

    // basic 8-beat fill, iter 3
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, k == 7, k, 32'h100 + k, 3, 1'b0, 0);
      if (k == 0) chk("basic_busy_after_sos", 64'(fill_busy), 64'd1);
      if (k == 6) chk("basic_done_early", 64'(fill_done), 64'd0);
    end
    chk("basic_fill_done", 64'(fill_done), 64'd1);
    chk("basic_buf_valid", 64'(buf_valid), 64'd1);
    chk("basic_rd_iter",   64'(rd_iter),   64'd3);
    chk("basic_beat_cnt",  64'(beat_cnt),  64'd8);
    idle_read(1'b1, 5);
    chk("basic_rd_data", 64'(rd_data), 64'h105);
    chk("basic_done_pulse_end", 64'(fill_done), 64'd0);

    // ping-pong overlap: second fill while reading addr 2 every cycle
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, k == 7, k, 32'h200 + k, 4, 1'b1, 2);
      chk("pp_old_data", 64'(rd_data), 64'h102);
    end
    chk("pp_old_iter_gone", 64'(rd_iter), 64'd4);
    idle_read(1'b1, 2);
    chk("pp_new_data", 64'(rd_data), 64'h202);

    // single-beat stream
    drive(1'b1, 1'b1, 0, 32'hABC, 2, 1'b0, 0);
    chk("single_busy",     64'(fill_busy), 64'd0);
    chk("single_done",     64'(fill_done), 64'd1);
    chk("single_beat_cnt", 64'(beat_cnt),  64'd1);
    chk("single_rd_iter",  64'(rd_iter),   64'd2);
    idle_read(1'b1, 0);
    chk("single_rd_data", 64'(rd_data), 64'hABC);
    chk("err_clean", 64'(err), 64'd0);

    // overflow: DEPTH+2 beats, A wraps on the line address
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(i == 0, i == DEPTH + 1, i, 32'h400 + i, 1, 1'b0, 0);
      if (i == DEPTH - 1) begin
        chk("ovf_cnt_at_depth", 64'(beat_cnt), 64'd64);
        chk("ovf_err_at_depth", 64'(err),      64'd0);
      end
    end
    chk("ovf_beat_cnt", 64'(beat_cnt), 64'd64);
    chk("ovf_err",      64'(err),      64'd1);
    idle_read(1'b1, 0);
    chk("ovf_rd0", 64'(rd_data), 64'h440);
    idle_read(1'b1, 1);
    chk("ovf_rd1", 64'(rd_data), 64'h441);
    idle_read(1'b1, 2);
    chk("ovf_rd2", 64'(rd_data), 64'h402);

    // sos again at beat 3 restarts the fill
    for (int k = 0; k < 3; k++) drive(k == 0, 1'b0, k, 32'h300 + k, 5, 1'b0, 0);
    drive(1'b1, 1'b0, 0, 32'h350, 6, 1'b0, 0);
    chk("restart_busy", 64'(fill_busy), 64'd1);
    chk("restart_cnt",  64'(beat_cnt),  64'd1);
    for (int a = 1; a <= 4; a++) drive(1'b0, a == 4, a, 32'h300 + a, 6, 1'b0, 0);
    chk("restart_done",    64'(fill_done), 64'd1);
    chk("restart_beat_cnt", 64'(beat_cnt), 64'd5);
    chk("restart_rd_iter", 64'(rd_iter),   64'd6);
    chk("restart_err",     64'(err),       64'd1);
    idle_read(1'b1, 0);
    chk("restart_rd0", 64'(rd_data), 64'h350);
    idle_read(1'b1, 4);
    chk("restart_rd4", 64'(rd_data), 64'h304);

    // reset asserted asynchronously at beat 4 of a fill
    for (int k = 0; k < 4; k++) drive(k == 0, 1'b0, k, 32'h500 + k, 7, 1'b1, 1);
    stream_in.sos     = 1'b0;
    stream_in.A       = FV_ADDR_W'(4);
    stream_in.FV_data = FV_BW'(32'h504);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_buf_valid", 64'(buf_valid), 64'd0);
    chk("rst_fill_busy", 64'(fill_busy), 64'd0);
    chk("rst_beat_cnt",  64'(beat_cnt),  64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("rst_rd_data",   64'(rd_data),   64'd0);
    chk("rst_rd_iter",   64'(rd_iter),   64'd0);
    stream_in = '0;
    rd_en     = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle_read(1'b1, 1);
    chk("post_rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("post_rst_rd_data",   64'(rd_data),   64'd0);
    chk("post_rst_buf_valid", 64'(buf_valid), 64'd0);
    idle_read(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
